// File: rtl/sdram_arbiter.sv
// sdram_arbiter
//   Shares one SDRAM controller between the Z80 memory path, the boot/ROM
//   image loader and refresh (CPU RFSH cycles plus an internal interval timer).
//   Grants one fixed-length strobe slot at a time, followed by a one-clock gap.
// Ports
//   clock, reset (sync, active-low), ready (core initialised; low acts as reset)
//   cpuRd/cpuWr/cpuRfsh (active-low levels), cpuA, cpuD -> cpuQ, cpuWait
//   ldReq, ldA, ldD -> ldAck (one-clock pulse at completion)
//   sdrRd/sdrWr/sdrRfsh (active-low strobes), sdrA, sdrD -> core; sdrQ <- core
module sdram_arbiter #(
  parameter int unsigned SLOT      = 8,
  parameter int unsigned RINTERVAL = 384,
  parameter int unsigned AW        = 24
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ready,
  input  logic          cpuRd,
  input  logic          cpuWr,
  input  logic          cpuRfsh,
  input  logic [AW-1:0] cpuA,
  input  logic [7:0]    cpuD,
  output logic [7:0]    cpuQ,
  output logic          cpuWait,
  input  logic          ldReq,
  input  logic [AW-1:0] ldA,
  input  logic [7:0]    ldD,
  output logic          ldAck,
  output logic          sdrRd,
  output logic          sdrWr,
  output logic          sdrRfsh,
  output logic [AW-1:0] sdrA,
  output logic [15:0]   sdrD,
  input  logic [15:0]   sdrQ
);

  localparam int unsigned CW = $clog2(SLOT + 1);
  localparam int unsigned TW = $clog2(RINTERVAL + 1);
  localparam logic [CW-1:0] COUNT_LAST = CW'(SLOT - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(RINTERVAL - 1);

  typedef enum logic [2:0] {S_IDLE, S_CPU, S_RFSH, S_LOAD, S_GAP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          tpend_q, tpend_d;
  logic          cpu_pend_q, cpu_pend_d;
  logic          cpu_op_wr_q, cpu_op_wr_d;
  logic          cpu_served_q, cpu_served_d;
  logic          rf_pend_q, rf_pend_d;
  logic          rf_served_q, rf_served_d;
  logic          cur_wr_q, cur_wr_d;
  logic          sdr_rd_q, sdr_rd_d;
  logic          sdr_wr_q, sdr_wr_d;
  logic          sdr_rfsh_q, sdr_rfsh_d;
  logic [AW-1:0] sdr_a_q, sdr_a_d;
  logic [15:0]   sdr_d_q, sdr_d_d;
  logic [7:0]    cpu_q_q, cpu_q_d;
  logic          cpu_wait_q, cpu_wait_d;
  logic          ld_ack_q, ld_ack_d;

  logic cpu_lvl, cap_cpu, cap_rf, cpu_req, cpu_wr_req, rf_req;
  logic sdr_q_hi_unused;

  always_comb sdr_q_hi_unused = ^sdrQ[15:8];

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    tpend_d      = tpend_q;
    cpu_pend_d   = cpu_pend_q;
    cpu_op_wr_d  = cpu_op_wr_q;
    cpu_served_d = cpu_served_q;
    rf_pend_d    = rf_pend_q;
    rf_served_d  = rf_served_q;
    cur_wr_d     = cur_wr_q;
    sdr_rd_d     = sdr_rd_q;
    sdr_wr_d     = sdr_wr_q;
    sdr_rfsh_d   = sdr_rfsh_q;
    sdr_a_d      = sdr_a_q;
    sdr_d_d      = sdr_d_q;
    cpu_q_d      = cpu_q_q;
    ld_ack_d     = 1'b0;

    // A request is taken once per Z80 strobe: the served flag blocks
    // re-capture until the level has returned high.
    cpu_lvl    = !cpuRd || !cpuWr;
    cap_cpu    = cpu_lvl && !cpu_served_q && !cpu_pend_q;
    cap_rf     = !cpuRfsh && !rf_served_q && !rf_pend_q;
    cpu_req    = cpu_pend_q || cap_cpu;
    cpu_wr_req = cpu_pend_q ? cpu_op_wr_q : !cpuWr;
    rf_req     = rf_pend_q || cap_rf;

    if (cap_cpu) begin
      cpu_pend_d  = 1'b1;
      cpu_op_wr_d = !cpuWr;
    end
    if (cap_rf) rf_pend_d = 1'b1;
    if (!cpu_lvl) cpu_served_d = 1'b0;
    if (cpuRfsh) rf_served_d = 1'b0;

    timer_d = (timer_q == TIMER_LAST) ? timer_q : timer_q + TW'(1);
    if (timer_d == TIMER_LAST) tpend_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        count_d = '0;
        // Capture and grant may happen on the same clock so that a CPU
        // request arriving together with the loader still wins.
        if (cpu_req) begin
          state_d      = S_CPU;
          cpu_pend_d   = 1'b0;
          cpu_served_d = 1'b1;
          cur_wr_d     = cpu_wr_req;
          sdr_a_d      = cpuA;
          sdr_d_d      = {2{cpuD}};
          if (cpu_wr_req) sdr_wr_d = 1'b0;
          else            sdr_rd_d = 1'b0;
        end else if (rf_req || tpend_q) begin
          state_d    = S_RFSH;
          rf_pend_d  = 1'b0;
          tpend_d    = 1'b0;
          timer_d    = '0;
          sdr_rfsh_d = 1'b0;
          if (rf_req) rf_served_d = 1'b1;
        end else if (ldReq) begin
          state_d  = S_LOAD;
          sdr_a_d  = ldA;
          sdr_d_d  = {2{ldD}};
          sdr_wr_d = 1'b0;
        end
      end
      S_CPU, S_RFSH, S_LOAD: begin
        count_d = count_q + CW'(1);
        if (count_q == COUNT_LAST) begin
          state_d    = S_GAP;
          sdr_rd_d   = 1'b1;
          sdr_wr_d   = 1'b1;
          sdr_rfsh_d = 1'b1;
          if (state_q == S_CPU && !cur_wr_q) cpu_q_d = sdrQ[7:0];
          if (state_q == S_LOAD) ld_ack_d = 1'b1;
        end
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Wait covers pending, the slot itself and the gap clock after a CPU slot.
    cpu_wait_d = cpu_pend_d || (state_d == S_CPU) ||
                 (state_d == S_GAP && state_q == S_CPU);
  end

  always_ff @(posedge clock) begin
    if (!reset || !ready) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      timer_q      <= '0;
      tpend_q      <= 1'b0;
      cpu_pend_q   <= 1'b0;
      cpu_op_wr_q  <= 1'b0;
      cpu_served_q <= 1'b0;
      rf_pend_q    <= 1'b0;
      rf_served_q  <= 1'b0;
      cur_wr_q     <= 1'b0;
      sdr_rd_q     <= 1'b1;
      sdr_wr_q     <= 1'b1;
      sdr_rfsh_q   <= 1'b1;
      sdr_a_q      <= '0;
      sdr_d_q      <= '0;
      cpu_q_q      <= '0;
      cpu_wait_q   <= 1'b0;
      ld_ack_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      timer_q      <= timer_d;
      tpend_q      <= tpend_d;
      cpu_pend_q   <= cpu_pend_d;
      cpu_op_wr_q  <= cpu_op_wr_d;
      cpu_served_q <= cpu_served_d;
      rf_pend_q    <= rf_pend_d;
      rf_served_q  <= rf_served_d;
      cur_wr_q     <= cur_wr_d;
      sdr_rd_q     <= sdr_rd_d;
      sdr_wr_q     <= sdr_wr_d;
      sdr_rfsh_q   <= sdr_rfsh_d;
      sdr_a_q      <= sdr_a_d;
      sdr_d_q      <= sdr_d_d;
      cpu_q_q      <= cpu_q_d;
      cpu_wait_q   <= cpu_wait_d;
      ld_ack_q     <= ld_ack_d;
    end
  end

  assign sdrRd   = sdr_rd_q;
  assign sdrWr   = sdr_wr_q;
  assign sdrRfsh = sdr_rfsh_q;
  assign sdrA    = sdr_a_q;
  assign sdrD    = sdr_d_q;
  assign cpuQ    = cpu_q_q;
  assign cpuWait = cpu_wait_q;
  assign ldAck   = ld_ack_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter
//   Scoreboard bench for sdram_arbiter. Stimulus tasks push expected slots
//   (kind/address/data) into queues; a negedge monitor reconstructs each
//   strobe slot seen on the core side and pops/compares. Refresh slots are
//   judged against a clock-distance model of the refresh interval.
module tb_sdram_arbiter;

  localparam int unsigned SLOT = 8;
  localparam int unsigned RINT = 384;
  localparam int unsigned AW   = 24;
  localparam int BOUND = RINT + 3 * SLOT + 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          ready = 1'b1;
  logic          cpuRd = 1'b1, cpuWr = 1'b1, cpuRfsh = 1'b1;
  logic [AW-1:0] cpuA = '0, ldA = '0;
  logic [7:0]    cpuD = '0, ldD = '0;
  logic          ldReq = 1'b0;
  logic [15:0]   sdrQ = '0;
  logic [7:0]    cpuQ;
  logic          cpuWait, ldAck, sdrRd, sdrWr, sdrRfsh;
  logic [AW-1:0] sdrA;
  logic [15:0]   sdrD;

  sdram_arbiter #(.SLOT(SLOT), .RINTERVAL(RINT), .AW(AW)) dut (
    .clock(clock), .reset(reset), .ready(ready),
    .cpuRd(cpuRd), .cpuWr(cpuWr), .cpuRfsh(cpuRfsh), .cpuA(cpuA), .cpuD(cpuD),
    .cpuQ(cpuQ), .cpuWait(cpuWait),
    .ldReq(ldReq), .ldA(ldA), .ldD(ldD), .ldAck(ldAck),
    .sdrRd(sdrRd), .sdrWr(sdrWr), .sdrRfsh(sdrRfsh), .sdrA(sdrA), .sdrD(sdrD),
    .sdrQ(sdrQ)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         kind;   // 0 cpu read, 1 cpu write, 3 loader write
    logic [23:0] addr;
    logic [7:0]  data;  // write byte, or expected cpuQ for reads
  } exp_t;

  exp_t exp_q[$];
  int   rf_q[$];        // clock index at which a CPU rfsh was issued
  int   checks = 0;
  int   errors = 0;
  int   pcyc = 0;       // posedge counter
  int   last_zero = 0;  // posedge at which the refresh distance restarted
  int   slot_cnt[3] = '{0, 0, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  always @(posedge clock) begin
    pcyc = pcyc + 1;
    if (!reset || !ready) last_zero = pcyc;
  end

  // Monitor: slot reconstruction on the core interface
  logic        in_slot = 1'b0, post = 1'b0, stable = 1'b1;
  int          s_kind, s_len, post_kind, nlow, gap;
  logic [23:0] s_addr;
  exp_t        cur;

  always @(negedge clock) begin
    if (!reset || !ready) begin
      in_slot = 1'b0;
      post    = 1'b0;
      exp_q.delete();
      rf_q.delete();
    end else begin
      if (post) begin
        post = 1'b0;
        if (post_kind == 3) chk("ldack_width", ldAck, 1'b0);
        if (post_kind == 0 || post_kind == 1) chk("wait_drop", cpuWait, 1'b0);
      end
      if (in_slot) begin
        if ((s_kind == 0 && !sdrRd) || (s_kind == 1 && !sdrWr) || (s_kind == 2 && !sdrRfsh)) begin
          s_len++;
          if (sdrA !== s_addr) stable = 1'b0;
        end else begin
          in_slot = 1'b0;
          chk("slot_len", s_len, SLOT);
          chk("addr_stable", stable, 1'b1);
          if (s_kind != 2) begin
            post = 1'b1;
            post_kind = cur.kind;
            if (cur.kind == 0) chk("cpu_q", cpuQ, cur.data);
            if (cur.kind != 3) chk("wait_in_gap", cpuWait, 1'b1);
            if (cur.kind == 3) chk("ldack_pulse", ldAck, 1'b1);
          end
        end
      end
      nlow = int'(!sdrRd) + int'(!sdrWr) + int'(!sdrRfsh);
      if (!in_slot && nlow != 0) begin
        chk("one_strobe", nlow, 1);
        in_slot = 1'b1;
        stable  = 1'b1;
        s_len   = 1;
        s_addr  = sdrA;
        s_kind  = !sdrRd ? 0 : (!sdrWr ? 1 : 2);
        slot_cnt[s_kind]++;
        if (s_kind == 2) begin
          gap = pcyc - last_zero;
          if (rf_q.size() > 0 && rf_q[0] < pcyc) begin
            void'(rf_q.pop_front());
          end else begin
            chk("auto_rfsh_not_early", gap >= int'(RINT), 1'b1);
            chk("auto_rfsh_not_late", gap <= BOUND, 1'b1);
          end
          last_zero = pcyc;
        end else if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_slot: kind %0d addr 0x%0h, required none", s_kind, sdrA);
          cur = '{kind: (s_kind == 0) ? 0 : 1, addr: sdrA, data: 8'h00};
        end else begin
          cur = exp_q.pop_front();
          if (s_kind == 0) chk("slot_is_read", cur.kind, 0);
          else chk("slot_is_write", (cur.kind == 1 || cur.kind == 3), 1'b1);
          chk("slot_addr", sdrA, cur.addr);
          if (cur.kind != 0) chk("slot_data", sdrD, {cur.data, cur.data});
        end
      end
    end
  end

  task automatic wait_cpu_done();
    bit seen = 0;
    for (int n = 0; n < 120; n++) begin
      tick();
      if (cpuWait) seen = 1;
      else if (seen) break;
    end
    chk("cpu_done", (seen && !cpuWait), 1'b1);
  endtask

  task automatic cpu_access(input bit wr, input logic [23:0] a, input logic [7:0] d,
                            input logic [7:0] q);
    logic [7:0] hi;
    hi = 8'($urandom);
    sdrQ = {hi, q};
    exp_q.push_back('{kind: wr ? 1 : 0, addr: a, data: wr ? d : q});
    cpuA = a;
    cpuD = d;
    if (wr) cpuWr = 1'b0;
    else cpuRd = 1'b0;
    wait_cpu_done();
    cpuRd = 1'b1;
    cpuWr = 1'b1;
    tick();
  endtask

  task automatic ld_access(input logic [23:0] a, input logic [7:0] d);
    bit got = 0;
    exp_q.push_back('{kind: 3, addr: a, data: d});
    ldA = a;
    ldD = d;
    ldReq = 1'b1;
    for (int n = 0; n < 120 && !got; n++) begin
      tick();
      if (ldAck) got = 1;
    end
    chk("ld_ack_seen", got, 1'b1);
    ldReq = 1'b0;
    tick();
  endtask

  task automatic rfsh_pulse();
    rf_q.push_back(pcyc);
    cpuRfsh = 1'b0;
    tick();
    tick();
    cpuRfsh = 1'b1;
    repeat (SLOT + 4) tick();
  endtask

  initial begin
    int n, c0;
    bit any;
    // reset state
    repeat (4) tick();
    chk("rst_strobes", {sdrRd, sdrWr, sdrRfsh}, 3'b111);
    chk("rst_cpuq", cpuQ, 8'h00);
    chk("rst_wait", cpuWait, 1'b0);
    chk("rst_ldack", ldAck, 1'b0);
    chk("rst_sdra", sdrA, 24'h0);
    reset = 1'b1;

    // automatic refresh after exactly RINTERVAL idle clocks
    n = 0;
    while (sdrRfsh && n < 2 * int'(RINT)) begin
      tick();
      n++;
    end
    chk("auto_rfsh_time", n, RINT);

    // CPU rfsh mid-interval restarts the timer: cpu slot plus one later auto
    repeat (100) tick();
    c0 = slot_cnt[2];
    rfsh_pulse();
    repeat (RINT + 30) tick();
    chk("rfsh_count", slot_cnt[2] - c0, 2);

    // CPU read, level held low afterwards must not repeat
    c0 = slot_cnt[0];
    sdrQ = 16'h5A5A;
    exp_q.push_back('{kind: 0, addr: 24'h00C000, data: 8'h5A});
    cpuA = 24'h00C000;
    cpuRd = 1'b0;
    wait_cpu_done();
    repeat (20) tick();
    chk("rd_single_slot", slot_cnt[0] - c0, 1);
    cpuRd = 1'b1;
    tick();

    // CPU write and loader in the same clock: CPU first
    exp_q.push_back('{kind: 1, addr: 24'h008000, data: 8'h22});
    exp_q.push_back('{kind: 3, addr: 24'h040000, data: 8'h11});
    cpuA = 24'h008000; cpuD = 8'h22; ldA = 24'h040000; ldD = 8'h11;
    cpuWr = 1'b0;
    ldReq = 1'b1;
    any = 0;
    for (int i = 0; i < 80 && !any; i++) begin
      tick();
      if (ldAck) any = 1;
    end
    chk("both_done", any, 1'b1);
    ldReq = 1'b0;
    cpuWr = 1'b1;
    repeat (3) tick();

    // ready low blocks grants; a slot starts soon after ready rises
    ready = 1'b0;
    cpuA = 24'h001234;
    sdrQ = 16'h00A7;
    cpuRd = 1'b0;
    any = 0;
    repeat (10) begin
      tick();
      if (!sdrRd || !sdrWr || !sdrRfsh) any = 1;
    end
    chk("no_grant_unready", any, 1'b0);
    exp_q.push_back('{kind: 0, addr: 24'h001234, data: 8'hA7});
    ready = 1'b1;
    n = 0;
    while (sdrRd && n < 10) begin
      tick();
      n++;
    end
    chk("ready_latency", (n >= 1 && n <= 2), 1'b1);
    wait_cpu_done();
    cpuRd = 1'b1;
    tick();

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: cpu_access(1'b0, 24'($urandom), 8'($urandom), 8'($urandom));
        1: cpu_access(1'b1, 24'($urandom), 8'($urandom), 8'($urandom));
        2: rfsh_pulse();
        default: ld_access(24'($urandom), 8'($urandom));
      endcase
      repeat ($urandom_range(1, 4)) tick();
    end
    repeat (2 * SLOT + 4) tick();
    chk("exp_drained", exp_q.size(), 0);
    chk("rfsh_drained", rf_q.size(), 0);

    // reset in slot clock 3 of a loader write
    exp_q.push_back('{kind: 3, addr: 24'h050000, data: 8'h33});
    ldA = 24'h050000; ldD = 8'h33;
    ldReq = 1'b1;
    n = 0;
    while (sdrWr && n < 40) begin
      tick();
      n++;
    end
    chk("ld_slot_started", sdrWr, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    ldReq = 1'b0;
    tick();
    chk("abort_strobes", {sdrRd, sdrWr, sdrRfsh}, 3'b111);
    any = 0;
    repeat (12) begin
      tick();
      if (ldAck) any = 1;
    end
    chk("abort_no_ack", any, 1'b0);
    reset = 1'b1;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
